// File: rtl/rv_bits_insert_buf.sv
// Purpose: inserts an S-bit field at bit POS of an N-bit word, 2-entry elastic buffer.
// Latency: 1 cycle from input accept to valid_out; 1 word/cycle sustained.
// Backpressure: absorbs one extra word after ready_out drops; ready_in comes from registered state only.
module rv_bits_insert_buf #(
    parameter int N   = 3,
    parameter int S   = 1,
    parameter int POS = 0
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           valid_in,
    output logic           ready_in,
    input  logic [N-1:0]   data_in,
    input  logic [S-1:0]   ins_in,
    output logic           valid_out,
    input  logic           ready_out,
    output logic [N+S-1:0] data_out
);

    localparam int W = N + S;

    // Reject parameter sets that cannot describe a legal bit placement.
    generate
        if (N < 1) begin : g_bad_n
            $error("rv_bits_insert_buf: N must be >= 1");
        end
        if (S < 1) begin : g_bad_s
            $error("rv_bits_insert_buf: S must be >= 1");
        end
        if ((POS < 0) || (POS > N)) begin : g_bad_pos
            $error("rv_bits_insert_buf: POS must be within 0..N");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   m_q, m_d;
    logic [W-1:0]   k_q, k_d;
    logic [W-1:0]   ins_w;
    logic           accept;
    logic           consume;

    // Bit placement is resolved per output bit at elaboration, so POS==0 and
    // POS==N need no special-case zero-width slices.
    for (genvar i = 0; i < W; i++) begin : g_bit
        if (i < POS) begin : g_lo
            assign ins_w[i] = data_in[i];
        end else if (i < POS + S) begin : g_fld
            assign ins_w[i] = ins_in[i-POS];
        end else begin : g_hi
            assign ins_w[i] = data_in[i-S];
        end
    end

    // ready_in only looks at stored state and reset, never at ready_out.
    assign ready_in  = (state_q != ST_FULL) && reset;
    assign valid_out = (state_q != ST_EMPTY);
    assign data_out  = m_q;
    assign accept    = valid_in && ready_in;
    assign consume   = valid_out && ready_out;

    // Occupancy FSM: M always holds the oldest word, K the overflow word.
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        k_d     = k_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d = ST_ONE;
                    m_d     = ins_w;
                end
            end
            ST_ONE: begin
                if (accept && consume) begin
                    m_d = ins_w;
                end else if (accept) begin
                    state_d = ST_FULL;
                    k_d     = ins_w;
                end else if (consume) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (consume) begin
                    state_d = ST_ONE;
                    m_d     = k_q;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // State and storage registers with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_EMPTY;
            m_q     <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            k_q     <= k_d;
        end
    end

endmodule

// File: tb/tb_rv_bits_insert_buf.sv
// Purpose: scoreboard bench for rv_bits_insert_buf (N=8,S=2,POS=3 plus POS=0/POS=8 builds).
// Latency: expects each accepted word on data_out one edge after acceptance.
// Backpressure: exercises stalls, FULL state and random ready_out.
module tb_rv_bits_insert_buf;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       valid_in = 1'b0;
    logic       ready_in;
    logic [7:0] data_in = '0;
    logic [1:0] ins_in = '0;
    logic       valid_out;
    logic       ready_out = 1'b0;
    logic [9:0] data_out;

    logic       valid_e = 1'b0;
    logic       ready_out_e = 1'b0;
    logic [7:0] data_e = '0;
    logic [1:0] ins_e = '0;
    logic       ready_in_e0, valid_out_e0, ready_in_e8, valid_out_e8;
    logic [9:0] data_out_e0, data_out_e8;

    int checks = 0;
    int errors = 0;
    logic [9:0] q[$];

    always #5 clk = ~clk;

    rv_bits_insert_buf #(.N(8), .S(2), .POS(3)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(ready_in),
        .data_in(data_in), .ins_in(ins_in), .valid_out(valid_out),
        .ready_out(ready_out), .data_out(data_out)
    );

    rv_bits_insert_buf #(.N(8), .S(2), .POS(0)) dut_e0 (
        .clk(clk), .reset(reset), .valid_in(valid_e), .ready_in(ready_in_e0),
        .data_in(data_e), .ins_in(ins_e), .valid_out(valid_out_e0),
        .ready_out(ready_out_e), .data_out(data_out_e0)
    );

    rv_bits_insert_buf #(.N(8), .S(2), .POS(8)) dut_e8 (
        .clk(clk), .reset(reset), .valid_in(valid_e), .ready_in(ready_in_e8),
        .data_in(data_e), .ins_in(ins_e), .valid_out(valid_out_e8),
        .ready_out(ready_out_e), .data_out(data_out_e8)
    );

    // Reference placement built from masks and shifts.
    function automatic logic [9:0] ins_model(input logic [7:0] d, input logic [1:0] f, input int pos);
        logic [9:0] dw;
        logic [9:0] mask;
        dw   = {2'b00, d};
        mask = (10'd1 << pos) - 10'd1;
        return ((dw & ~mask) << 2) | ({8'd0, f} << pos) | (dw & mask);
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid_out: got %b want 0", valid_out); end
        checks++;
        if (data_out !== 10'd0) begin errors++; $display("FAIL reset_data_out: got %h want 000", data_out); end
        checks++;
        if (ready_in !== 1'b0) begin errors++; $display("FAIL reset_ready_in: got %b want 0", ready_in); end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (ready_in !== 1'b1) begin errors++; $display("FAIL reset_release_ready_in: got %b want 1", ready_in); end
    endtask

    task automatic test_basic();
        ready_out = 1'b1;
        valid_in  = 1'b1;
        data_in   = 8'hA5;
        ins_in    = 2'b11;
        @(posedge clk); #1;
        valid_in = 1'b0;
        @(negedge clk);
        checks++;
        if (valid_out !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", valid_out); end
        checks++;
        if (data_out !== 10'h29D) begin errors++; $display("FAIL basic_data: got %h want 29d", data_out); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (valid_out !== 1'b0) begin errors++; $display("FAIL basic_valid_drop: got %b want 0", valid_out); end
        @(posedge clk); #1;
    endtask

    task automatic test_edges();
        ready_out_e = 1'b1;
        valid_e     = 1'b1;
        data_e      = 8'hFF;
        ins_e       = 2'b00;
        @(posedge clk); #1;
        valid_e = 1'b0;
        @(negedge clk);
        checks++;
        if (valid_out_e0 !== 1'b1 || data_out_e0 !== 10'h3FC) begin
            errors++; $display("FAIL edge_pos0: got v=%b d=%h want v=1 d=3fc", valid_out_e0, data_out_e0);
        end
        checks++;
        if (valid_out_e8 !== 1'b1 || data_out_e8 !== 10'h0FF) begin
            errors++; $display("FAIL edge_posN: got v=%b d=%h want v=1 d=0ff", valid_out_e8, data_out_e8);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_stream();
        int sent = 0;
        int got = 0;
        int run = 0;
        int max_run = 0;
        logic [9:0] e;
        ready_out = 1'b1;
        for (int c = 0; c < 40; c++) begin
            valid_in = (sent < 32);
            data_in  = 8'(sent * 7 + 1);
            ins_in   = 2'(sent);
            @(negedge clk);
            if (valid_in) begin
                checks++;
                if (ready_in !== 1'b1) begin errors++; $display("FAIL stream_ready_in cycle %0d: got %b want 1", c, ready_in); end
            end
            if (valid_out) begin run++; if (run > max_run) max_run = run; end else run = 0;
            if (valid_out && ready_out) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL stream_extra_word: got %h want none", data_out);
                end else begin
                    e = q.pop_front();
                    if (data_out !== e) begin errors++; $display("FAIL stream_data %0d: got %h want %h", got, data_out, e); end
                end
                got++;
            end
            if (valid_in && ready_in) begin
                q.push_back(ins_model(data_in, ins_in, 3));
                sent++;
            end
            @(posedge clk); #1;
        end
        valid_in = 1'b0;
        checks++;
        if (got != 32) begin errors++; $display("FAIL stream_count: got %0d want 32", got); end
        checks++;
        if (max_run != 32) begin errors++; $display("FAIL stream_consecutive: got %0d want 32", max_run); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] wd [3];
        logic [1:0] wf [3];
        int sent = 0;
        int got = 0;
        logic stalled = 1'b0;
        logic [9:0] prev = '0;
        logic [9:0] e;
        wd[0] = 8'h11; wd[1] = 8'h22; wd[2] = 8'h33;
        wf[0] = 2'b01; wf[1] = 2'b10; wf[2] = 2'b11;
        for (int c = 0; c < 10; c++) begin
            ready_out = (c >= 3);
            valid_in  = (sent < 3);
            data_in   = (sent < 3) ? wd[sent] : 8'h00;
            ins_in    = (sent < 3) ? wf[sent] : 2'b00;
            @(negedge clk);
            if (c == 2) begin
                checks++;
                if (ready_in !== 1'b0) begin errors++; $display("FAIL bp_full_ready_in: got %b want 0", ready_in); end
            end
            if (stalled) begin
                checks++;
                if (data_out !== prev) begin errors++; $display("FAIL bp_stable cycle %0d: got %h want %h", c, data_out, prev); end
            end
            if (valid_out && ready_out) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL bp_extra_word: got %h want none", data_out);
                end else begin
                    e = q.pop_front();
                    if (data_out !== e) begin errors++; $display("FAIL bp_data %0d: got %h want %h", got, data_out, e); end
                end
                got++;
            end
            if (valid_in && ready_in) begin
                q.push_back(ins_model(data_in, ins_in, 3));
                sent++;
            end
            stalled = valid_out && !ready_out;
            prev    = data_out;
            @(posedge clk); #1;
        end
        valid_in = 1'b0;
        checks++;
        if (got != 3 || q.size() != 0) begin errors++; $display("FAIL bp_count: got %0d left %0d want 3 left 0", got, q.size()); end
    endtask

    task automatic test_random();
        int got = 0;
        int sent = 0;
        logic r;
        logic [9:0] e;
        for (int c = 0; c < 10020; c++) begin
            valid_in  = (c < 10000) ? 1'($urandom_range(0, 1)) : 1'b0;
            ready_out = (c < 10000) ? 1'($urandom_range(0, 1)) : 1'b1;
            data_in   = 8'($urandom);
            ins_in    = 2'($urandom);
            @(negedge clk);
            r = ready_in;
            ready_out = ~ready_out;
            #1;
            if ((c % 10) == 0) begin
                checks++;
                if (ready_in !== r) begin errors++; $display("FAIL rand_ready_path cycle %0d: got %b want %b", c, ready_in, r); end
            end
            ready_out = ~ready_out;
            #1;
            if (valid_out && ready_out) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL rand_extra_word cycle %0d: got %h want none", c, data_out);
                end else begin
                    e = q.pop_front();
                    if (data_out !== e) begin errors++; $display("FAIL rand_data cycle %0d: got %h want %h", c, data_out, e); end
                end
                got++;
            end
            if (valid_in && ready_in) begin
                q.push_back(ins_model(data_in, ins_in, 3));
                sent++;
            end
            @(posedge clk); #1;
        end
        valid_in = 1'b0;
        checks++;
        if (got != sent || q.size() != 0) begin errors++; $display("FAIL rand_count: got %0d want %0d", got, sent); end
    endtask

    task automatic test_reset_full();
        ready_out = 1'b0;
        valid_in  = 1'b1;
        data_in   = 8'h5A; ins_in = 2'b01;
        @(posedge clk); #1;
        data_in   = 8'hC3; ins_in = 2'b10;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (ready_in !== 1'b0 || valid_out !== 1'b1) begin
            errors++; $display("FAIL rst_full_setup: got rdy=%b vld=%b want rdy=0 vld=1", ready_in, valid_out);
        end
        @(posedge clk); #1;
        reset     = 1'b0;
        ready_out = 1'b1;
        data_in   = 8'h77;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (valid_out !== 1'b0 || data_out !== 10'd0 || ready_in !== 1'b0) begin
            errors++; $display("FAIL rst_full_clear: got vld=%b d=%h rdy=%b want vld=0 d=000 rdy=0", valid_out, data_out, ready_in);
        end
        @(posedge clk); #1;
        reset    = 1'b1;
        valid_in = 1'b0;
        q.delete();
        @(negedge clk);
        checks++;
        if (ready_in !== 1'b1) begin errors++; $display("FAIL rst_release_ready_in: got %b want 1", ready_in); end
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            checks++;
            if (valid_out !== 1'b0) begin errors++; $display("FAIL rst_stale_word cycle %0d: got %b want 0", c, valid_out); end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_edges();
        test_stream();
        test_back_to_back();
        test_random();
        test_reset_full();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
